// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard decoder bus: raw PS/2 pins in, decoded scan codes and held key levels out.
// The decoder takes the slave modport; whatever drives the PS/2 pins takes master.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    logic       key_space;
    logic       key_right;
    logic       key_left;

    modport master (
        output ps2_clk, ps2_data,
        input  scan_code, scan_valid, frame_err, key_space, key_right, key_left
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output scan_code, scan_valid, frame_err, key_space, key_right, key_left
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver plus make/break decoder for the space, left-arrow and right-arrow keys.
// Optional macro PS2_PARITY_CHECK_EN turns on odd-parity rejection of received bytes.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_decoder_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          frame_ok;

    rx_state_t     rx_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    scan_code_q;
    logic          scan_valid_q, frame_err_q;

    dec_state_t    dec_state;
    logic          key_space_q, key_right_q, key_left_q;

    // NOTE: synchronisers reset to 1 so the bus looks idle and no false falling edge appears on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            parity_ok <= 1'b0;
        else if (fall && rx_state == RX_PARITY)
            parity_ok <= ^{dat_s2, shift};
    end

    assign frame_ok = dat_s2 & parity_ok;
`else
    assign frame_ok = dat_s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state     <= RX_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            idle_cnt     <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (rx_state == RX_IDLE || fall)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (rx_state != RX_IDLE && !fall && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                rx_state    <= RX_IDLE;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                unique case (rx_state)
                    RX_IDLE: begin
                        if (!dat_s2) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            rx_state <= RX_PARITY;
                    end
                    RX_PARITY: rx_state <= RX_STOP;
                    RX_STOP: begin
                        rx_state <= RX_IDLE;
                        if (frame_ok) begin
                            scan_code_q  <= shift;
                            scan_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Prefix tracker: E0 marks extended codes, F0 marks a release of the following code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_state   <= DEC_BASE;
            key_space_q <= 1'b0;
            key_right_q <= 1'b0;
            key_left_q  <= 1'b0;
        end else if (scan_valid_q) begin
            dec_state <= DEC_BASE;
            unique case (dec_state)
                DEC_BASE: begin
                    if (scan_code_q == 8'hE0)      dec_state   <= DEC_EXT;
                    else if (scan_code_q == 8'hF0) dec_state   <= DEC_BRK;
                    else if (scan_code_q == 8'h29) key_space_q <= 1'b1;
                end
                DEC_BRK: begin
                    if (scan_code_q == 8'h29) key_space_q <= 1'b0;
                end
                DEC_EXT: begin
                    if (scan_code_q == 8'hE0)      dec_state   <= DEC_EXT;
                    else if (scan_code_q == 8'hF0) dec_state   <= DEC_EXT_BRK;
                    else if (scan_code_q == 8'h6B) key_left_q  <= 1'b1;
                    else if (scan_code_q == 8'h74) key_right_q <= 1'b1;
                end
                DEC_EXT_BRK: begin
                    if (scan_code_q == 8'h6B)      key_left_q  <= 1'b0;
                    else if (scan_code_q == 8'h74) key_right_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scan_code  = scan_code_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.key_space  = key_space_q;
    assign bus.key_right  = key_right_q;
    assign bus.key_left   = key_left_q;
endmodule
